// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and constants shared by the UART receiver and transmitter
package uart_pkg;
    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_DIVISOR = 5208;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: bus-side view of the receiver (read strobe in, byte and status out)
interface uart_rx_if;
    import uart_pkg::*;
    logic                 rd_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 rx_ready_o;
    logic                 frame_err_o;
    logic                 overrun_o;
    logic                 busy_o;
    modport slave  (input rd_i, output data_o, rx_ready_o, frame_err_o, overrun_o, busy_o);
    modport master (output rd_i, input data_o, rx_ready_o, frame_err_o, overrun_o, busy_o);
endinterface

// File: rtl/uart_sync.sv
// uart_sync: flop chain bringing an asynchronous idle-high line into the clock domain
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    always_comb sync_d = {sync_q[STAGES-2:0], d_i};
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) sync_q <= '1;
        else         sync_q <= sync_d;
    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling mid-bit, holding one byte with sticky status until read
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_DIVISOR = DEFAULT_DIVISOR,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    uart_rx_if.slave   bus
);
    localparam int CW = $clog2(UART_DIVISOR);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(UART_DIVISOR / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(UART_DIVISOR - 1);

    logic                 rxs;
    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 prev_q, prev_d, rx_ready_q, rx_ready_d;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d, busy_q, busy_d;
    logic                 tick, valid, ferr;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rxd_i),
        .q_o   (rxs)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid   = 1'b0;
        ferr    = 1'b0;
        prev_d  = rxs;
        tick    = cnt_q == '0;
        case (state_q)
            ST_IDLE: if (prev_q && !rxs) begin
                cnt_d   = CNT_HALF;
                state_d = ST_START;
            end
            ST_START: if (!tick) cnt_d = cnt_q - 1'b1;
                else if (rxs) state_d = ST_IDLE;
                else begin
                    cnt_d   = CNT_FULL;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            ST_DATA: if (!tick) cnt_d = cnt_q - 1'b1;
                else begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BW'(DATA_BITS - 1)) ? ST_STOP : ST_DATA;
                end
            ST_STOP: if (!tick) cnt_d = cnt_q - 1'b1;
                else if (rxs) begin
                    valid   = 1'b1;
                    data_d  = shift_q;
                    state_d = ST_IDLE;
                end else begin
                    ferr    = 1'b1;
                    state_d = ST_BREAK;
                end
            ST_BREAK: state_d = rxs ? ST_IDLE : ST_BREAK;
            default:  state_d = ST_IDLE;
        endcase
        // a completing event in the same cycle as a read wins over the clear
        rx_ready_d  = valid ? 1'b1 : (bus.rd_i ? 1'b0 : rx_ready_q);
        frame_err_d = ferr ? 1'b1 : (bus.rd_i ? 1'b0 : frame_err_q);
        overrun_d   = (valid && rx_ready_q && !bus.rd_i) ? 1'b1 : (bus.rd_i ? 1'b0 : overrun_q);
        busy_d      = state_d != ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            prev_q      <= 1'b1;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            prev_q      <= prev_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end

    assign bus.data_o      = data_q;
    assign bus.rx_ready_o  = rx_ready_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random 8N1 frames checked against a rule-level receiver model
module tb_uart_rx;
    localparam int D    = 16;
    localparam int SYNC = 2;
    localparam int STOP_K = SYNC + 1 + D / 2 + 9 * D - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_data = '0;
    logic exp_ready = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
    logic r_pre, r_post, b_pre, b_post;

    uart_rx_if bus();

    uart_rx #(.UART_DIVISOR(D), .SYNC_STAGES(SYNC)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .rxd_i (rxd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_data"}, 32'(bus.data_o), 32'(exp_data));
        chk({tag, "_ready"}, 32'(bus.rx_ready_o), 32'(exp_ready));
        chk({tag, "_ferr"}, 32'(bus.frame_err_o), 32'(exp_ferr));
        chk({tag, "_ovr"}, 32'(bus.overrun_o), 32'(exp_ovr));
    endtask

    function automatic logic bitval(input logic [7:0] b, input logic s, input int idx);
        return idx == 0 ? 1'b0 : (idx <= 8 ? b[idx-1] : s);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read(input int n);
        bus.rd_i = 1'b1;
        wait_clks(n);
        bus.rd_i = 1'b0;
        {exp_ready, exp_ferr, exp_ovr} = '0;
    endtask

    // rd_k pulses the read strobe in the k-th cycle; STOP_K aligns it with the stop sample
    task automatic send(input logic [7:0] b, input logic s, input int rd_k, input int abort_k);
        logic rd_at_stop;
        rd_at_stop = rd_k == STOP_K;
        rxd = 1'b0;
        for (int k = 1; k < 10 * D; k++) begin
            @(negedge clk);
            if (k == abort_k) return;
            bus.rd_i = k == rd_k;
            rxd = bitval(b, s, k / D);
            if (k == STOP_K) begin r_pre = bus.rx_ready_o; b_pre = bus.busy_o; end
            if (k == STOP_K + 1) begin r_post = bus.rx_ready_o; b_post = bus.busy_o; end
        end
        @(negedge clk);
        bus.rd_i = 1'b0;
        if (s) begin
            exp_ovr   = rd_at_stop ? 1'b0 : (exp_ovr | exp_ready);
            exp_ferr  = rd_at_stop ? 1'b0 : exp_ferr;
            exp_ready = 1'b1;
            exp_data  = b;
            wait_clks(3);
        end else begin
            exp_ferr  = 1'b1;
            exp_ready = rd_at_stop ? 1'b0 : exp_ready;
            exp_ovr   = rd_at_stop ? 1'b0 : exp_ovr;
        end
    endtask

    initial begin
        bus.rd_i = 1'b0;
        wait_clks(2);
        chk_all("reset");
        chk("reset_busy", 32'(bus.busy_o), 0);
        rst_n = 1'b1;
        wait_clks(4);

        send(8'h55, 1'b1, 0, 0);
        chk("t1_ready_before", 32'(r_pre), 0);
        chk("t1_ready_at", 32'(r_post), 1);
        chk("t1_busy_before", 32'(b_pre), 1);
        chk("t1_busy_at", 32'(b_post), 0);
        chk_all("t1");
        read(1);
        chk_all("t1_read");

        rxd = 1'b0;
        wait_clks(4);
        rxd = 1'b1;
        wait_clks(2);
        chk("t2_busy_hi", 32'(bus.busy_o), 1);
        wait_clks(14);
        chk("t2_busy_lo", 32'(bus.busy_o), 0);
        chk_all("t2");

        send(8'hA3, 1'b0, 0, 0);
        wait_clks(40);
        chk_all("t3_break");
        chk("t3_busy_break", 32'(bus.busy_o), 1);
        rxd = 1'b1;
        wait_clks(5);
        chk("t3_busy_idle", 32'(bus.busy_o), 0);
        send(8'h0F, 1'b1, 0, 0);
        chk_all("t3_next");
        read(1);

        send(8'h12, 1'b1, 0, 0);
        send(8'h34, 1'b1, 0, 0);
        chk_all("t4_ovr");
        read(3);
        chk_all("t4_read");

        send(8'h11, 1'b1, 0, 0);
        send(8'h7E, 1'b1, STOP_K, 0);
        chk_all("t5_rd_at_stop");

        send(8'hFF, 1'b1, 0, 5 * D + 8);
        rst_n = 1'b0;
        #1;
        {exp_data, exp_ready, exp_ferr, exp_ovr} = '0;
        chk_all("t6_reset");
        chk("t6_busy", 32'(bus.busy_o), 0);
        @(negedge clk);
        rxd = 1'b1;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(3);
        send(8'hC3, 1'b1, 0, 0);
        chk_all("t6_after");

        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send(b, 1'b1, ($urandom_range(0, 2) == 0) ? STOP_K : 0, 0);
            chk_all("rand");
            if ($urandom_range(0, 1) == 1) read($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial 8N1 receiver front-end.
- Sits directly upstream of the Wishbone UART register interface and supplies its received byte, ready flag and error flags.
- Oversamples rxd with the system clock using a clocks-per-bit divisor and samples at mid-bit.
- Holds one received byte, with sticky status, until the bus side reads it.

Parameters:
UART_DIVISOR, 5208, system clocks per bit (50 MHz / 9600); legal range >= 4; HALF = UART_DIVISOR/2 (integer division)
SYNC_STAGES, 2, synchroniser flop count on rxd_i; legal range >= 2

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
rxd_i  input  1  asynchronous serial input, idle high
rd_i  input  1  level read strobe from bus side; clears status flags
data_o  output  8  last valid received byte
rx_ready_o  output  1  sticky: unread byte present in data_o
frame_err_o  output  1  sticky: stop bit sampled low
overrun_o  output  1  sticky: valid byte completed while rx_ready_o already set and not being read
busy_o  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; synchroniser flops and previous-sample flop = 1; data_o = 0x00; rx_ready_o = 0; frame_err_o = 0; overrun_o = 0; busy_o = 0; counters = 0. Reset mid-frame discards the partial byte.
- rxs = synchronised rxd_i (SYNC_STAGES flops).
- Falling edge = previous rxs 1 and current rxs 0.
- FSM states and transitions:
  - IDLE: on falling edge, load bit counter with HALF-1 and go to START.
  - START: count down to 0, then sample rxs. If 0: load UART_DIVISOR-1, clear bit index, go to DATA. If 1 (glitch): go to IDLE with no flag change.
  - DATA: count down to 0, sample rxs into shift register LSB first, reload UART_DIVISOR-1. After the 8th sample, go to STOP.
  - STOP: count down to 0, then sample rxs.
    - Sample 1: data_o <= shift register; rx_ready_o <= 1; go to IDLE.
    - Sample 0: frame_err_o <= 1; data_o and rx_ready_o unchanged; go to BREAK.
  - BREAK: stay until rxs = 1, then go to IDLE. A held-low line produces only one frame error.
- Timing:
  - Stop sample occurs HALF + 9*UART_DIVISOR clocks after the edge-detect cycle.
  - rx_ready_o rises on the following clock.
  - End-to-end from the rxd_i transition adds SYNC_STAGES + 1 clocks.
- Overrun: valid stop while rx_ready_o = 1 and rd_i = 0 sets overrun_o = 1. The new byte still overwrites data_o.
- rd_i clears rx_ready_o, frame_err_o and overrun_o on the next edge. Because rd_i is a level, multi-cycle assertion is harmless.
- Simultaneous events (set wins over clear):
  - Valid stop with rd_i = 1 in the same cycle: rx_ready_o stays 1, overrun_o is not set, data_o takes the new byte.
  - Framing error with rd_i = 1 in the same cycle: frame_err_o = 1.
- Counters wrap never: they are reloaded before reaching 0 - 1. Counter width = clog2(UART_DIVISOR).
- A falling edge while in BREAK, START, DATA or STOP is ignored.

Decomposition:
- Shared package uart_pkg holds: FSM state encodings (IDLE, START, DATA, STOP, BREAK), DATA_BITS = 8, and the default divisor constant. uart_pkg is shared with the transmitter.
- Sub-module uart_sync: SYNC_STAGES flop chain, reset value 1. It is reusable for the CTS/RTS inputs.
- The FSM, counters and flags remain in uart_rx.

Test Plan (UART_DIVISOR = 16, so HALF = 8):
1. Valid frame 0x55 -> after exactly 152 clocks from edge detect, rx_ready_o = 1 and data_o = 0x55; frame_err_o = 0; busy_o falls the same cycle rx_ready_o rises. Then rd_i for 1 clock -> rx_ready_o = 0.
2. rxd_i low for 4 clocks, then high -> START rejects; busy_o returns to 0; rx_ready_o and data_o unchanged.
3. Frame 0xA3 with stop bit low, line held low for 40 more clocks -> frame_err_o = 1, rx_ready_o = 0, busy_o stays 1 until rxd returns high. A following valid frame 0x0F is received correctly.
4. Frames 0x12 then 0x34 with no rd_i -> data_o = 0x34, rx_ready_o = 1, overrun_o = 1. rd_i for 3 clocks -> all flags 0.
5. rx_ready_o already set; rd_i asserted exactly in the stop-sample cycle of frame 0x7E -> rx_ready_o = 1, data_o = 0x7E, overrun_o = 0.
6. Assert rst_ni low during DATA bit 4, release, then send 0xC3 -> all outputs 0 immediately on reset; 0xC3 is received with no errors.
